// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter.
//   - BUS_WIDTH_DEFAULT    : default width of every address/data bus
//   - STARVE_LIMIT_DEFAULT : default number of back-to-back data grants
//                            tolerated while a fetch is waiting
//   - arb_state_e          : arbiter FSM state encoding
package mem_bus_arbiter_pkg;

    localparam int BUS_WIDTH_DEFAULT    = 32;
    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_starve_counter.sv
// Fetch starvation counter.
// Counts data grants issued while a fetch request is waiting. Cleared when
// the fetch is granted or when no fetch is pending, and saturates at
// STARVE_LIMIT. at_limit is registered so the arbiter sees a clean flag.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   fetch_pending  : fetch request currently asserted
//   data_grant     : data port granted on this edge
//   fetch_grant    : fetch port granted on this edge
//   at_limit       : counter equals STARVE_LIMIT
module arb_starve_counter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic fetch_pending,
    input  logic data_grant,
    input  logic fetch_grant,
    output logic at_limit
);

    localparam int            CW      = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);
    localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;

    // Next count: clear on fetch service or no waiting fetch, else count data grants.
    always_comb begin
        count_nxt_s = count_r;
        if (fetch_grant) begin
            count_nxt_s = ZERO_C;
        end else if (!fetch_pending) begin
            count_nxt_s = ZERO_C;
        end else if (data_grant) begin
            if (count_r == LIMIT_C) begin
                count_nxt_s = count_r;
            end else begin
                count_nxt_s = count_r + ONE_C;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Counter and limit flag registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r  <= ZERO_C;
            at_limit <= (LIMIT_C == ZERO_C);
        end else begin
            count_r  <= count_nxt_s;
            at_limit <= (count_nxt_s == LIMIT_C);
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter (instruction fetch + data) onto a single
// synchronous memory. Each access takes an ISSUE cycle (strobe + grant)
// and a RESP cycle (read data returned), so one access per two cycles.
// Data has priority unless a fetch has been passed over STARVE_LIMIT times.
// Ports:
//   clk, reset                         : clock, async active-high reset
//   i_req/i_addr -> i_gnt/i_rvalid/i_rdata : fetch (read-only) port
//   d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata : data port
//   m_addr/m_re/m_wr/m_wdata, m_rdata  : memory side; m_rdata valid the
//                                        cycle after m_re
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int BUS_WIDTH    = BUS_WIDTH_DEFAULT,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [BUS_WIDTH-1:0] i_addr,
    output logic                 i_gnt,
    output logic                 i_rvalid,
    output logic [BUS_WIDTH-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [BUS_WIDTH-1:0] d_addr,
    input  logic [BUS_WIDTH-1:0] d_wdata,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [BUS_WIDTH-1:0] d_rdata,
    output logic [BUS_WIDTH-1:0] m_addr,
    output logic                 m_re,
    output logic                 m_wr,
    output logic [BUS_WIDTH-1:0] m_wdata,
    input  logic [BUS_WIDTH-1:0] m_rdata
);

    arb_state_e state_r;
    arb_state_e state_nxt_s;

    logic any_req_s;
    logic arb_slot_s;
    logic grant_s;
    logic fetch_win_s;
    logic data_win_s;
    logic starve_hit_s;

    // Kind of the access currently in flight, used to route rvalid in RESP.
    logic lat_fetch_r;
    logic lat_read_r;
    logic lat_fetch_nxt_s;
    logic lat_read_nxt_s;

    logic                 i_gnt_nxt_s;
    logic                 d_gnt_nxt_s;
    logic                 i_rvalid_nxt_s;
    logic                 d_rvalid_nxt_s;
    logic                 m_re_nxt_s;
    logic                 m_wr_nxt_s;
    logic [BUS_WIDTH-1:0] m_addr_nxt_s;
    logic [BUS_WIDTH-1:0] m_wdata_nxt_s;

    // Arbitration happens only on edges leaving IDLE or RESP.
    assign any_req_s  = i_req | d_req;
    assign arb_slot_s = (state_r == ST_IDLE) || (state_r == ST_RESP);
    assign grant_s    = arb_slot_s & any_req_s;

    // Fetch wins when alone or when it has been starved long enough.
    assign fetch_win_s = i_req & (~d_req | starve_hit_s);
    assign data_win_s  = d_req & ~fetch_win_s;

    // Read data is passed straight through from memory on both ports.
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    arb_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk           (clk),
        .reset         (reset),
        .fetch_pending (i_req),
        .data_grant    (grant_s & data_win_s),
        .fetch_grant   (grant_s & fetch_win_s),
        .at_limit      (starve_hit_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (any_req_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered outputs and latched access kind.
    always_comb begin
        i_gnt_nxt_s     = 1'b0;
        d_gnt_nxt_s     = 1'b0;
        i_rvalid_nxt_s  = 1'b0;
        d_rvalid_nxt_s  = 1'b0;
        m_re_nxt_s      = 1'b0;
        m_wr_nxt_s      = 1'b0;
        m_addr_nxt_s    = m_addr;
        m_wdata_nxt_s   = m_wdata;
        lat_fetch_nxt_s = lat_fetch_r;
        lat_read_nxt_s  = lat_read_r;

        // Entering ISSUE: latch the winner and drive its strobe and grant.
        if (grant_s) begin
            if (fetch_win_s) begin
                i_gnt_nxt_s     = 1'b1;
                m_re_nxt_s      = 1'b1;
                m_addr_nxt_s    = i_addr;
                lat_fetch_nxt_s = 1'b1;
                lat_read_nxt_s  = 1'b1;
            end else begin
                d_gnt_nxt_s     = 1'b1;
                m_re_nxt_s      = ~d_we;
                m_wr_nxt_s      = d_we;
                m_addr_nxt_s    = d_addr;
                m_wdata_nxt_s   = d_wdata;
                lat_fetch_nxt_s = 1'b0;
                lat_read_nxt_s  = ~d_we;
            end
        end else begin
            lat_fetch_nxt_s = lat_fetch_r;
            lat_read_nxt_s  = lat_read_r;
        end

        // Entering RESP: flag read data for whichever port issued a read.
        if (state_r == ST_ISSUE) begin
            i_rvalid_nxt_s = lat_fetch_r & lat_read_r;
            d_rvalid_nxt_s = ~lat_fetch_r & lat_read_r;
        end else begin
            i_rvalid_nxt_s = 1'b0;
            d_rvalid_nxt_s = 1'b0;
        end
    end

    // Registered outputs and latched access kind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_gnt       <= 1'b0;
            d_gnt       <= 1'b0;
            i_rvalid    <= 1'b0;
            d_rvalid    <= 1'b0;
            m_re        <= 1'b0;
            m_wr        <= 1'b0;
            m_addr      <= {BUS_WIDTH{1'b0}};
            m_wdata     <= {BUS_WIDTH{1'b0}};
            lat_fetch_r <= 1'b0;
            lat_read_r  <= 1'b0;
        end else begin
            i_gnt       <= i_gnt_nxt_s;
            d_gnt       <= d_gnt_nxt_s;
            i_rvalid    <= i_rvalid_nxt_s;
            d_rvalid    <= d_rvalid_nxt_s;
            m_re        <= m_re_nxt_s;
            m_wr        <= m_wr_nxt_s;
            m_addr      <= m_addr_nxt_s;
            m_wdata     <= m_wdata_nxt_s;
            lat_fetch_r <= lat_fetch_nxt_s;
            lat_read_r  <= lat_read_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: table of request vectors plus
// hand-written starvation and reset-abort sequences, checked through a
// queue of expected grants filled when requests are posted.
module tb_mem_bus_arbiter;

    localparam int BW = 32;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req;
    logic [BW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [BW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [BW-1:0] d_addr;
    logic [BW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [BW-1:0] d_rdata;
    logic [BW-1:0] m_addr;
    logic          m_re;
    logic          m_wr;
    logic [BW-1:0] m_wdata;
    logic [BW-1:0] m_rdata;

    mem_bus_arbiter #(.BUS_WIDTH(BW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_addr(m_addr), .m_re(m_re), .m_wr(m_wr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_data;
        logic          we;
        logic [BW-1:0] addr;
        logic [BW-1:0] wdata;
    } acc_t;

    typedef struct {
        logic          f_en;
        logic [BW-1:0] f_addr;
        logic          d_en;
        logic          d_we;
        logic [BW-1:0] d_addr;
        logic [BW-1:0] d_wdata;
        logic          data_first;
    } vec_t;

    acc_t          exp_q[$];
    logic [BW-1:0] fq[$];
    acc_t          dq[$];
    int            grant_cyc[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic          exp_i_rv = 1'b0;
    logic          exp_d_rv = 1'b0;
    logic [BW-1:0] exp_rdata = 32'h0;
    vec_t          vecs[7];

    function automatic logic [BW-1:0] mem_val(input logic [BW-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0FF_EE11;
    endfunction

    // Synchronous memory: read data appears the cycle after m_re, junk otherwise.
    always @(posedge clk) begin
        if (m_re) m_rdata <= mem_val(m_addr);
        else      m_rdata <= 32'h0BAD_0BAD;
    end

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_agents();
        if (fq.size() > 0) begin
            i_req  = 1'b1;
            i_addr = fq[0];
        end else begin
            i_req = 1'b0;
        end
        if (dq.size() > 0) begin
            d_req   = 1'b1;
            d_we    = dq[0].we;
            d_addr  = dq[0].addr;
            d_wdata = dq[0].wdata;
        end else begin
            d_req = 1'b0;
        end
    endtask

    // One clock: check responses and grants, then update the requesters.
    task automatic step();
        acc_t e;
        @(posedge clk);
        #1;
        cyc++;
        chk("i_rvalid", i_rvalid, exp_i_rv);
        chk("d_rvalid", d_rvalid, exp_d_rv);
        if (exp_i_rv) chk("i_rdata", i_rdata, exp_rdata);
        if (exp_d_rv) chk("d_rdata", d_rdata, exp_rdata);
        exp_i_rv = 1'b0;
        exp_d_rv = 1'b0;
        if (i_gnt || d_gnt) begin
            chk("single_gnt", i_gnt & d_gnt, 1'b0);
            grant_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_gnt: i_gnt=%b d_gnt=%b, none expected (cycle %0d)", i_gnt, d_gnt, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("gnt_owner_is_data", d_gnt, e.is_data);
                chk("m_addr", m_addr, e.addr);
                chk("m_re", m_re, !e.we);
                chk("m_wr", m_wr, e.we);
                if (e.we) chk("m_wdata", m_wdata, e.wdata);
                if (!e.we) begin
                    exp_rdata = mem_val(e.addr);
                    if (e.is_data) exp_d_rv = 1'b1;
                    else           exp_i_rv = 1'b1;
                end
            end
        end else begin
            chk("m_re_idle", m_re, 1'b0);
            chk("m_wr_idle", m_wr, 1'b0);
        end
        if (i_gnt && i_req && fq.size() > 0) void'(fq.pop_front());
        if (d_gnt && d_req && dq.size() > 0) void'(dq.pop_front());
        drive_agents();
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || exp_i_rv || exp_d_rv) && n < budget) begin
            step();
            n++;
        end
        if (exp_q.size() > 0 || exp_i_rv || exp_d_rv) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d grants outstanding after %0d cycles", exp_q.size(), budget);
            exp_q.delete();
            fq.delete();
            dq.delete();
            exp_i_rv = 1'b0;
            exp_d_rv = 1'b0;
            drive_agents();
        end
        step();
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        acc_t fa;
        acc_t da;
        int   start;
        fa = '{is_data: 1'b0, we: 1'b0, addr: v.f_addr, wdata: 32'h0};
        da = '{is_data: 1'b1, we: v.d_we, addr: v.d_addr, wdata: v.d_wdata};
        grant_cyc.delete();
        start = cyc;
        if (v.f_en) fq.push_back(v.f_addr);
        if (v.d_en) dq.push_back(da);
        if (v.data_first) begin
            if (v.d_en) exp_q.push_back(da);
            if (v.f_en) exp_q.push_back(fa);
        end else begin
            if (v.f_en) exp_q.push_back(fa);
            if (v.d_en) exp_q.push_back(da);
        end
        drive_agents();
        run_until_idle(20);
        if (grant_cyc.size() > 0) chk($sformatf("req_to_gnt_v%0d", idx), grant_cyc[0] - start, 1);
        if (v.f_en && v.d_en && grant_cyc.size() > 1)
            chk($sformatf("gnt_spacing_v%0d", idx), grant_cyc[1] - grant_cyc[0], 2);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_i_gnt"}, i_gnt, 1'b0);
        chk({tag, "_d_gnt"}, d_gnt, 1'b0);
        chk({tag, "_i_rvalid"}, i_rvalid, 1'b0);
        chk({tag, "_d_rvalid"}, d_rvalid, 1'b0);
        chk({tag, "_m_re"}, m_re, 1'b0);
        chk({tag, "_m_wr"}, m_wr, 1'b0);
        chk({tag, "_m_addr"}, m_addr, 32'h0);
        chk({tag, "_m_wdata"}, m_wdata, 32'h0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        acc_t a;
        vecs[0] = '{f_en: 1'b1, f_addr: 32'h0000_0010, d_en: 1'b0, d_we: 1'b0, d_addr: 32'h0, d_wdata: 32'h0, data_first: 1'b0};
        vecs[1] = '{f_en: 1'b0, f_addr: 32'h0, d_en: 1'b1, d_we: 1'b1, d_addr: 32'h0000_0200, d_wdata: 32'hDEAD_BEEF, data_first: 1'b1};
        vecs[2] = '{f_en: 1'b1, f_addr: 32'h0000_0020, d_en: 1'b1, d_we: 1'b0, d_addr: 32'h0000_0300, d_wdata: 32'h0, data_first: 1'b1};
        vecs[3] = '{f_en: 1'b1, f_addr: 32'h0000_1000, d_en: 1'b1, d_we: 1'b1, d_addr: 32'h0000_0044, d_wdata: 32'h1234_5678, data_first: 1'b1};
        vecs[4] = '{f_en: 1'b0, f_addr: 32'h0, d_en: 1'b1, d_we: 1'b0, d_addr: 32'hFFFF_FFFC, d_wdata: 32'h0, data_first: 1'b1};
        vecs[5] = '{f_en: 1'b1, f_addr: 32'h0000_0000, d_en: 1'b0, d_we: 1'b0, d_addr: 32'h0, d_wdata: 32'h0, data_first: 1'b0};
        vecs[6] = '{f_en: 1'b1, f_addr: 32'h0000_0ABC, d_en: 1'b1, d_we: 1'b1, d_addr: 32'h0000_0000, d_wdata: 32'hFFFF_FFFF, data_first: 1'b1};

        reset = 1'b1;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        step();
        step();

        for (int k = 0; k < 7; k++) apply_vec(vecs[k], k);

        // Data held with fetch waiting: four data grants, then fetch, twice over.
        grant_cyc.delete();
        fq.push_back(32'h0000_0040);
        fq.push_back(32'h0000_0044);
        for (int k = 0; k < 9; k++) begin
            a = '{is_data: 1'b1, we: logic'(k % 2), addr: 32'h0000_0500 + 32'(4 * k), wdata: 32'h1111_0000 + 32'(k)};
            dq.push_back(a);
        end
        for (int k = 0; k < 4; k++) exp_q.push_back(dq[k]);
        exp_q.push_back('{is_data: 1'b0, we: 1'b0, addr: 32'h0000_0040, wdata: 32'h0});
        for (int k = 4; k < 8; k++) exp_q.push_back(dq[k]);
        exp_q.push_back('{is_data: 1'b0, we: 1'b0, addr: 32'h0000_0044, wdata: 32'h0});
        exp_q.push_back(dq[8]);
        drive_agents();
        run_until_idle(60);
        chk("starve_grant_count", grant_cyc.size(), 11);
        for (int k = 1; k < grant_cyc.size(); k++)
            chk($sformatf("starve_spacing_%0d", k), grant_cyc[k] - grant_cyc[k-1], 2);

        // Reset during the ISSUE cycle of a data read abandons the access.
        a = '{is_data: 1'b1, we: 1'b0, addr: 32'h0000_0080, wdata: 32'h0};
        dq.push_back(a);
        exp_q.push_back(a);
        drive_agents();
        step();
        chk("abort_d_gnt_seen", d_gnt, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        exp_d_rv = 1'b0;
        exp_i_rv = 1'b0;
        dq.delete();
        drive_agents();
        step();
        reset = 1'b0;
        step();
        step();

        apply_vec('{f_en: 1'b1, f_addr: 32'h0000_0084, d_en: 1'b1, d_we: 1'b0, d_addr: 32'h0000_0088, d_wdata: 32'h0, data_first: 1'b1}, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter BUS_WIDTH, default 32, width of all address and data buses.
REQ-002 Parameter STARVE_LIMIT, default 4, maximum consecutive data grants while fetch is pending.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_req  input  1  fetch read request; held with i_addr stable until i_gnt.
REQ-006 i_addr  input  BUS_WIDTH  fetch address.
REQ-007 i_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-008 i_rvalid  output  1  one-cycle pulse: i_rdata valid.
REQ-009 i_rdata  output  BUS_WIDTH  fetch read data.
REQ-010 d_req  input  1  data request; held with d_we, d_addr, d_wdata stable until d_gnt.
REQ-011 d_we  input  1  1 = write, 0 = read.
REQ-012 d_addr  input  BUS_WIDTH  data address.
REQ-013 d_wdata  input  BUS_WIDTH  data write value.
REQ-014 d_gnt  output  1  one-cycle pulse: data request accepted (write committed).
REQ-015 d_rvalid  output  1  one-cycle pulse: d_rdata valid; reads only.
REQ-016 d_rdata  output  BUS_WIDTH  data read data.
REQ-017 m_addr  output  BUS_WIDTH  memory address.
REQ-018 m_re  output  1  memory read strobe.
REQ-019 m_wr  output  1  memory write strobe.
REQ-020 m_wdata  output  BUS_WIDTH  memory write data.
REQ-021 m_rdata  input  BUS_WIDTH  memory read data, valid the cycle after m_re.

Function
REQ-022 FSM states: IDLE, ISSUE, RESP; all outputs registered except i_rdata/d_rdata.
REQ-023 Transitions: IDLE, any req -> ISSUE; ISSUE -> RESP always; RESP, any req pending and not just granted -> ISSUE, else IDLE.
REQ-024 Arbitration decision made on the edge entering ISSUE from requests sampled that cycle; the winner's signals are latched.
REQ-025 Policy: data has priority, except when fetch is pending and the starve counter equals STARVE_LIMIT, fetch wins.
REQ-026 Starve counter: +1 on each data grant while i_req high; cleared on fetch grant or when i_req low; saturates at STARVE_LIMIT.
REQ-027 In ISSUE: m_addr = latched addr; m_re = 1 for read, m_wr = 1 for write; m_wdata = latched wdata; winner's gnt = 1 for exactly this cycle.
REQ-028 In RESP: m_re = m_wr = 0; the read winner's rvalid = 1 for exactly this cycle; *_rdata = m_rdata combinationally (both ports).
REQ-029 A requester sampled in RESP must not be the one granted in the preceding ISSUE (its req is deasserted or is a new request it raised after gnt).
REQ-030 Throughput: one access per 2 cycles; gnt-to-rvalid latency 1 cycle; req-to-gnt latency 1 cycle when uncontended.
REQ-031 Simultaneous i_req and d_req: exactly one gnt; the loser stays pending and is served in the next ISSUE unless preempted per REQ-025.
REQ-032 Outside ISSUE: m_re, m_wr, i_gnt, d_gnt = 0; m_addr and m_wdata hold their last values.

Reset
REQ-033 reset asserted: state = IDLE, starve counter = 0, all gnt/rvalid/m_re/m_wr = 0, m_addr = 0, m_wdata = 0, latched request cleared, immediately and asynchronously.
REQ-034 Reset during ISSUE or RESP abandons the access; no rvalid is produced afterwards.

Structure
REQ-035 Shared package holds the state encoding (IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2) and the BUS_WIDTH default.
REQ-036 One sub-module, arb_starve_counter, implements REQ-026; everything else is in mem_bus_arbiter.

Verification
REQ-037 i_req, i_addr = 0x10 alone -> i_gnt and m_re with m_addr = 0x10 in the next cycle; i_rvalid the cycle after, with i_rdata = m_rdata.
REQ-038 d_req write, d_addr = 0x200, d_wdata = 0xDEADBEEF -> one cycle of m_wr with those values plus d_gnt; no d_rvalid.
REQ-039 i_req and d_req (read) raised together -> d_gnt first, then i_gnt two cycles later.
REQ-040 d_req held continuously with i_req pending -> exactly 4 d_gnt pulses, then i_gnt, then the counter restarts.
REQ-041 reset pulsed in the ISSUE cycle of a read -> all outputs 0, no rvalid; a new request afterwards is served normally.
